// File: rtl/icache_readonly.sv
// Direct-mapped read-only instruction cache, 128-bit lines refilled from instruction memory.
// Latency: hit returns the word combinationally (0 cycles); a miss stalls for at least 2 cycles.
// Backpressure: proc_stall holds fetch during a refill; the refill waits on mem_ready indefinitely.
module icache_readonly #(
   parameter int NUM_BLOCKS = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          proc_read,
   input  logic [29:0]   proc_addr,
   output logic [31:0]   proc_rdata,
   output logic          proc_stall,
   output logic          mem_read,
   output logic [27:0]   mem_addr,
   input  logic [127:0]  mem_rdata,
   input  logic          mem_ready
);

   localparam int INDEX_W = $clog2(NUM_BLOCKS);
   localparam int TAG_W   = 28 - INDEX_W;

   typedef enum logic {IDLE, REFILL} state_t;

   state_t               state, next_state;
   logic [27:0]          mem_addr_r;
   logic [NUM_BLOCKS-1:0] valid;
   logic [TAG_W-1:0]     tag_arr  [NUM_BLOCKS];
   logic [127:0]         data_arr [NUM_BLOCKS];

   logic [1:0]           offset;
   logic [INDEX_W-1:0]   index;
   logic [TAG_W-1:0]     tag;
   logic                 hit;
   logic                 fill;
   logic [INDEX_W-1:0]   fill_idx;
   logic [TAG_W-1:0]     fill_tag;

   assign offset   = proc_addr[1:0];
   assign index    = proc_addr[INDEX_W+1:2];
   assign tag      = proc_addr[29:INDEX_W+2];
   assign hit      = proc_read & valid[index] & (tag_arr[index] == tag);
   assign fill_idx = mem_addr_r[INDEX_W-1:0];
   assign fill_tag = mem_addr_r[27:INDEX_W];

   // Word select from the indexed line; only meaningful when not stalled.
   assign proc_rdata = data_arr[index][{offset, 5'b0} +: 32];

   // Next-state and handshake outputs; a refill write is suppressed during reset.
   always_comb begin
      next_state = state;
      proc_stall = 1'b0;
      mem_read   = 1'b0;
      mem_addr   = '0;
      fill       = 1'b0;
      case (state)
         IDLE: begin
            proc_stall = proc_read & ~hit;
            if (proc_read && !hit) begin
               next_state = REFILL;
            end
         end
         REFILL: begin
            proc_stall = 1'b1;
            mem_read   = 1'b1;
            mem_addr   = mem_addr_r;
            if (mem_ready) begin
               fill       = ~rst;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Control state: FSM, latched block address and valid bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         mem_addr_r <= '0;
         valid      <= '0;
      end else begin
         state <= next_state;
         if (state == IDLE && proc_read && !hit) begin
            mem_addr_r <= proc_addr[29:2];
         end
         if (fill) begin
            valid[fill_idx] <= 1'b1;
         end
      end
   end

   // Tag and data arrays: written only on a refill, never reset.
   always_ff @(posedge clk) begin
      if (fill) begin
         tag_arr[fill_idx]  <= fill_tag;
         data_arr[fill_idx] <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_icache_readonly.sv
// Self-checking bench for icache_readonly: table of per-cycle vectors with expected outputs.
// Each vector is driven just after a rising edge and its expectation queued; the queue is
// popped and compared against the DUT on the following falling edge.
module tb_icache_readonly;

   logic          clk;
   logic          rst;
   logic          proc_read;
   logic [29:0]   proc_addr;
   logic [31:0]   proc_rdata;
   logic          proc_stall;
   logic          mem_read;
   logic [27:0]   mem_addr;
   logic [127:0]  mem_rdata;
   logic          mem_ready;

   icache_readonly #(.NUM_BLOCKS(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .proc_read  (proc_read),
      .proc_addr  (proc_addr),
      .proc_rdata (proc_rdata),
      .proc_stall (proc_stall),
      .mem_read   (mem_read),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          rst;
      logic          rd;
      logic [29:0]   addr;
      logic          rdy;
      logic [127:0]  mdat;
      logic          chk;
      logic          stall;
      logic          mrd;
      logic [27:0]   maddr;
      logic          chkd;
      logic [31:0]   rdat;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [127:0] L0 = 128'h44444444_33333333_22222222_11111111;
   localparam logic [127:0] LA = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
   localparam logic [127:0] LB = 128'hBBBB0003_BBBB0002_BBBB0001_BBBB0000;
   localparam logic [127:0] LX = 128'hDEADDEAD_DEADDEAD_DEADDEAD_DEADDEAD;

   function automatic logic [127:0] mk_line(input int i);
      logic [127:0] l;
      for (int w = 0; w < 4; w++) begin
         l[w*32 +: 32] = {16'hC0DE, 8'(i), 8'(w)};
      end
      return l;
   endfunction

   task automatic add(input logic r, input logic rd, input logic [29:0] a, input logic rdy,
                      input logic [127:0] md, input logic chk, input logic st, input logic mrd,
                      input logic [27:0] ma, input logic chkd, input logic [31:0] rdat);
      vec_t v;
      v.rst = r; v.rd = rd; v.addr = a; v.rdy = rdy; v.mdat = md;
      v.chk = chk; v.stall = st; v.mrd = mrd; v.maddr = ma; v.chkd = chkd; v.rdat = rdat;
      vecs.push_back(v);
   endtask

   task automatic cmp(input int id, input string what, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL vec%0d %s: got 0x%0h want 0x%0h", id, what, got, want);
      end
   endtask

   initial begin
      vec_t e;
      logic [127:0] li;
      rst = 1'b1; proc_read = 1'b0; proc_addr = '0; mem_rdata = '0; mem_ready = 1'b0;

      // Reset, then idle outputs after reset.
      add(1, 0, 30'h0, 0, '0, 0, 0, 0, 28'h0, 0, 32'h0);
      add(0, 0, 30'h0, 0, '0, 1, 0, 0, 28'h0, 0, 32'h0);
      // Cold miss: miss cycle, two waiting REFILL cycles, fill on third.
      add(0, 1, 30'h0, 0, '0, 1, 1, 0, 28'h0, 0, 32'h0);
      add(0, 1, 30'h0, 0, '0, 1, 1, 1, 28'h0, 0, 32'h0);
      add(0, 1, 30'h0, 0, '0, 1, 1, 1, 28'h0, 0, 32'h0);
      add(0, 1, 30'h0, 1, L0, 1, 1, 1, 28'h0, 0, 32'h0);
      add(0, 1, 30'h0, 0, '0, 1, 0, 0, 28'h0, 1, 32'h11111111);
      // Sequential hits.
      add(0, 1, 30'h1, 0, '0, 1, 0, 0, 28'h0, 1, 32'h22222222);
      add(0, 1, 30'h2, 0, '0, 1, 0, 0, 28'h0, 1, 32'h33333333);
      add(0, 1, 30'h3, 0, '0, 1, 0, 0, 28'h0, 1, 32'h44444444);
      // Conflict miss at 0x20 (index 0, tag 1), minimum penalty.
      add(0, 1, 30'h20, 0, '0, 1, 1, 0, 28'h0, 0, 32'h0);
      add(0, 1, 30'h20, 1, LA, 1, 1, 1, 28'h8, 0, 32'h0);
      add(0, 1, 30'h20, 0, '0, 1, 0, 0, 28'h0, 1, 32'hAAAA0000);
      add(0, 1, 30'h21, 0, '0, 1, 0, 0, 28'h0, 1, 32'hAAAA0001);
      // Address 0 was evicted.
      add(0, 1, 30'h0, 0, '0, 1, 1, 0, 28'h0, 0, 32'h0);
      add(0, 1, 30'h0, 1, L0, 1, 1, 1, 28'h0, 0, 32'h0);
      add(0, 1, 30'h0, 0, '0, 1, 0, 0, 28'h0, 1, 32'h11111111);
      // Reset during the second REFILL cycle of a miss at 0x24 (index 1, tag 1).
      add(0, 1, 30'h24, 0, '0, 1, 1, 0, 28'h0, 0, 32'h0);
      add(0, 1, 30'h24, 0, '0, 1, 1, 1, 28'h9, 0, 32'h0);
      add(1, 1, 30'h24, 1, LX, 1, 1, 1, 28'h9, 0, 32'h0);
      add(0, 0, 30'h0, 1, LX, 1, 0, 0, 28'h0, 0, 32'h0);
      add(0, 1, 30'h0, 0, '0, 1, 1, 0, 28'h0, 0, 32'h0);
      add(0, 1, 30'h0, 1, L0, 1, 1, 1, 28'h0, 0, 32'h0);
      add(0, 1, 30'h0, 0, '0, 1, 0, 0, 28'h0, 1, 32'h11111111);
      add(0, 1, 30'h24, 0, '0, 1, 1, 0, 28'h0, 0, 32'h0);
      add(0, 1, 30'h24, 1, LB, 1, 1, 1, 28'h9, 0, 32'h0);
      add(0, 1, 30'h24, 0, '0, 1, 0, 0, 28'h0, 1, 32'hBBBB0000);
      // Idle reads with mem_ready toggling, then the two resident lines still hit.
      for (int k = 0; k < 5; k++) begin
         add(0, 0, 30'h0, logic'(k % 2 == 0), LX, 1, 0, 0, 28'h0, 0, 32'h0);
      end
      add(0, 1, 30'h3, 0, '0, 1, 0, 0, 28'h0, 1, 32'h44444444);
      add(0, 1, 30'h25, 0, '0, 1, 0, 0, 28'h0, 1, 32'hBBBB0001);
      // Fill all lines from empty, then a second pass of pure hits.
      add(1, 0, 30'h0, 0, '0, 0, 0, 0, 28'h0, 0, 32'h0);
      for (int i = 0; i < 8; i++) begin
         li = mk_line(i);
         add(0, 1, 30'(4*i), 0, '0, 1, 1, 0, 28'h0, 0, 32'h0);
         add(0, 1, 30'(4*i), 1, li, 1, 1, 1, 28'(i), 0, 32'h0);
         add(0, 1, 30'(4*i + i%4), 0, '0, 1, 0, 0, 28'h0, 1, li[(i%4)*32 +: 32]);
      end
      for (int i = 0; i < 8; i++) begin
         li = mk_line(i);
         add(0, 1, 30'(4*i + (3 - i%4)), 0, '0, 1, 0, 0, 28'h0, 1, li[(3 - i%4)*32 +: 32]);
      end

      for (int n = 0; n < vecs.size(); n++) begin
         @(posedge clk);
         #1;
         rst       = vecs[n].rst;
         proc_read = vecs[n].rd;
         proc_addr = vecs[n].addr;
         mem_ready = vecs[n].rdy;
         mem_rdata = vecs[n].mdat;
         exp_q.push_back(vecs[n]);
         @(negedge clk);
         e = exp_q.pop_front();
         if (e.chk) begin
            cmp(n, "proc_stall", 32'(proc_stall), 32'(e.stall));
            cmp(n, "mem_read", 32'(mem_read), 32'(e.mrd));
            cmp(n, "mem_addr", 32'(mem_addr), 32'(e.maddr));
            if (e.chkd && !e.stall) begin
               cmp(n, "proc_rdata", proc_rdata, e.rdat);
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/icache_readonly.md
Name: icache_readonly

Overview:
- Direct-mapped, read-only instruction cache.
- Acts as the responder to the fetch stage's I-cache request port, which drives proc_addr/proc_read and consumes proc_rdata/proc_stall.
- Misses are refilled from a 128-bit-wide instruction memory through a request/ready handshake.
- Hits return a word in the same cycle. Misses stall the fetch stage until the line is filled.

Parameters:
- NUM_BLOCKS, 8, number of cache lines (power of 2, ≥2); INDEX_W = log2(NUM_BLOCKS).
- TAG_W, 28-INDEX_W (25 at default), tag bits stored per line. Derived value; not overridden independently.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- proc_read  in  1  fetch request, always high during normal operation
- proc_addr  in  30  word address (PC[31:2])
- proc_rdata  out  32  instruction word, raw memory byte order (fetch stage performs the endian swap)
- proc_stall  out  1  high = proc_rdata not valid, fetch must hold its PC
- mem_read  out  1  refill request to instruction memory
- mem_addr  out  28  block address (proc_addr[29:2])
- mem_rdata  in  128  refill line; word0 = [31:0] … word3 = [127:96]
- mem_ready  in  1  mem_rdata valid this cycle

Behaviour:
- Address split:
  - offset = proc_addr[1:0]
  - index = proc_addr[INDEX_W+1:2]
  - tag = proc_addr[29:INDEX_W+2]
- Storage per line: valid bit, TAG_W tag, 128-bit data. Storage is registers; no RAM macro.
- hit = proc_read & valid[index] & (tag_arr[index] == tag); evaluated combinationally.
- proc_rdata = data[index] word selected by offset, combinational.
  - Value is don't-care when proc_stall=1. The bench checks it only when proc_stall=0.
- States: IDLE, REFILL.
- IDLE:
  - proc_stall = proc_read & ~hit.
  - mem_read = 0.
  - On proc_read & ~hit: next state REFILL, latch the block address into mem_addr_r.
- REFILL:
  - proc_stall = 1.
  - mem_read = 1.
  - mem_addr = mem_addr_r, held stable for the whole request.
  - When mem_ready=1:
    - write mem_rdata into data[index of mem_addr_r];
    - write tag;
    - set valid;
    - next state IDLE.
  - When mem_ready=0: stay in REFILL, no timeout.
- Latency:
  - Hit: 0 cycles.
  - Miss: stall rises in the miss cycle and falls in the cycle after the mem_ready cycle. That cycle is an IDLE hit on the new line.
  - Minimum miss penalty is 2 cycles, when mem_ready is high in the first REFILL cycle.
- proc_addr is held stable by the fetch stage while stalled. The refill always uses the latched address and completes even if proc_read falls or proc_addr changes.
- proc_read=0 in IDLE: proc_stall=0, no refill starts, no state changes.
- mem_ready while in IDLE: ignored.
- Conflict miss (same index, different tag): the line is overwritten unconditionally. No dirty state, no write-back.
- Reset (rst=1 at a clock edge), including mid-REFILL:
  - all valid bits cleared, state=IDLE, mem_addr_r=0;
  - from the next cycle: mem_read=0, and proc_stall=proc_read (every access misses).
  - Data and tag arrays are not reset.
  - A mem_ready arriving in the same cycle as rst is discarded.
- Outputs after reset with proc_read=0: proc_stall=0, mem_read=0, mem_addr=0.
- mem_addr is 0 in IDLE.

Test Plan:
- Cold miss:
  - Stimulus: rst then release; proc_read=1, proc_addr=0x0000000; mem_ready=1 after 3 cycles with mem_rdata=0x44444444_33333333_22222222_11111111.
  - Required: proc_stall=1 and mem_read=1, mem_addr=0, for 3 cycles; REFILL ends on the mem_ready cycle; stall=0 the next cycle with proc_rdata=0x11111111.
- Sequential hits:
  - Stimulus: after the cold miss, proc_addr=1, 2, 3 in consecutive cycles.
  - Required: proc_stall=0 each cycle, proc_rdata=0x22222222, 0x33333333, 0x44444444, mem_read=0.
- Conflict miss:
  - Stimulus: proc_addr=0x20 (index 0, tag 1); mem_ready immediately with a new line of 0xAAAA….
  - Required: 2-cycle stall, mem_addr=0x8, then a hit returning the new word.
  - Stimulus: proc_addr=0x0 again.
  - Required: miss again, confirming eviction.
- Reset mid-refill:
  - Stimulus: assert rst during the second REFILL cycle, then assert mem_ready the cycle after reset is released.
  - Required: mem_read=0 the cycle after reset; mem_ready is ignored; proc_addr=0 misses again.
- Idle read:
  - Stimulus: proc_read=0 for 5 cycles with mem_ready toggling.
  - Required: proc_stall=0, mem_read=0, all valid bits unchanged.
- Fill all lines:
  - Stimulus: proc_addr = 4·i for i = 0…7.
  - Required: 8 misses; a second pass over the same addresses gives 8 hits with zero stall.
